// File: rtl/uart_rx_oversampled_pkg.sv
// Shared constants, FSM encoding and baud-divider arithmetic for the oversampled UART.
// Pure declarations; no timing or flow control of its own.
package uart_rx_oversampled_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DELIVER
    } state_t;

    // Clocks per oversample tick, rounded to nearest and never below one.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int d;
        d = (clk_hz + (baud * os) / 2) / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int calc_cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; tick fires every DIV clocks, restart realigns the phase.
// Restart zeroes the counter so the first tick lands DIV clocks later; no backpressure.
module uart_baud_tick
    import uart_rx_oversampled_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic restart,
    output logic tick
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int CW  = calc_cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: majority-voted bits, optional parity, 1-2 stop bits, sticky error flags.
// Word appears 3 cycles after the last stop-bit midpoint; a full holding register drops the new word and flags overrun.
module uart_rx_oversampled
    import uart_rx_oversampled_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 IN_SERIAL_RX,
    output logic [DATA_BITS-1:0] OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 IN_READY,
    output logic                 OUT_STATUS_IDLE,
    output logic                 OUT_ERR_FRAME,
    output logic                 OUT_ERR_PARITY,
    output logic                 OUT_ERR_OVERRUN,
    input  logic                 IN_ERR_CLEAR
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]    DB_N   = 4'(DATA_BITS);
    localparam logic [3:0]    SB_LAST = 4'(STOP_BITS - 1);
    localparam logic          ODD_ADJ = (PARITY == PARITY_ODD) ? 1'b1 : 1'b0;

    state_t               state_q, state_d;
    logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic [SW-1:0]        s_q, s_d;
    logic [1:0]           v_q, v_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 valid_q, valid_d, idle_q, idle_d;
    logic                 err_frame_q, err_frame_d, err_par_q, err_par_d, err_ovr_q, err_ovr_d;

    logic          rx, tick, restart, voted, par_exp, bit_end;
    logic          smp0, smp1, smp2;
    logic [SW-1:0] s_nxt;

    assign rx      = rx_s2_q;
    assign restart = (state_q == ST_IDLE) && !rx;

    uart_baud_tick #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .core_clk(CLK),
        .arst_n  (RESET_N),
        .restart (restart),
        .tick    (tick)
    );

    // Sample points are keyed on the count a tick advances to, so the third vote lands on bit-centre + 1.
    assign s_nxt   = (s_q == S_LAST) ? '0 : s_q + SW'(1);
    assign smp0    = tick && (s_nxt == S_V0);
    assign smp1    = tick && (s_nxt == S_V1);
    assign smp2    = tick && (s_nxt == S_V2);
    assign bit_end = tick && (s_q == S_LAST);
    assign voted   = (v_q[0] & v_q[1]) | (v_q[0] & rx) | (v_q[1] & rx);
    assign par_exp = (^shreg_q) ^ ODD_ADJ;

    always_comb begin
        state_d     = state_q;
        rx_s1_d     = IN_SERIAL_RX;
        rx_s2_d     = rx_s1_q;
        s_d         = tick ? s_nxt : s_q;
        v_d         = v_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        valid_d     = valid_q & ~IN_READY;
        err_frame_d = err_frame_q & ~IN_ERR_CLEAR;
        err_par_d   = err_par_q & ~IN_ERR_CLEAR;
        err_ovr_d   = err_ovr_q & ~IN_ERR_CLEAR;
        if (smp0) v_d[0] = rx;
        if (smp1) v_d[1] = rx;

        case (state_q)
            ST_IDLE: begin
                if (!rx) begin
                    state_d   = ST_START;
                    s_d       = '0;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            ST_START: begin
                if (smp1 && rx) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (smp2) begin
                    shreg_d   = {voted, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (bit_end && (bit_cnt_q == DB_N)) begin
                    state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_PARITY: begin
                if (smp2 && (voted != par_exp)) perr_d = 1'b1;
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Leave mid-bit on the last stop so an immediately following start edge is seen.
                if (smp2) begin
                    if (!voted) ferr_d = 1'b1;
                    if (bit_cnt_q == SB_LAST) state_d = ST_DELIVER;
                    else bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            ST_DELIVER: begin
                state_d = ST_IDLE;
                if (!valid_q || IN_READY) begin
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                end else begin
                    err_ovr_d = 1'b1;
                end
                if (ferr_q) err_frame_d = 1'b1;
                if (perr_q) err_par_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            s_q         <= '0;
            v_q         <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            valid_q     <= 1'b0;
            idle_q      <= 1'b1;
            err_frame_q <= 1'b0;
            err_par_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            s_q         <= s_d;
            v_q         <= v_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            valid_q     <= valid_d;
            idle_q      <= idle_d;
            err_frame_q <= err_frame_d;
            err_par_q   <= err_par_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    assign OUT_DATA        = data_q;
    assign OUT_VALID       = valid_q;
    assign OUT_STATUS_IDLE = idle_q;
    assign OUT_ERR_FRAME   = err_frame_q;
    assign OUT_ERR_PARITY  = err_par_q;
    assign OUT_ERR_OVERRUN = err_ovr_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed plus randomized frames on two receiver configurations, checked against a frame-level model.
// Delivered words are collected by a monitor at the falling edge; all other checks sample 1 unit after the rising edge.
module tb_uart_rx_oversampled;

    localparam int BC0 = 432;  // 8N1 default build: 27 clocks/tick * 16
    localparam int BC1 = 48;   // 7E2 build: 6 clocks/tick * 8

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1, rdy0 = 1'b1, clr0 = 1'b0;
    logic       rx1 = 1'b1, rdy1 = 1'b1, clr1 = 1'b0;
    logic [7:0] d0;
    logic [6:0] d1;
    logic       v0, idle0, fe0, pe0, ov0;
    logic       v1, idle1, fe1, pe1, ov1;

    int total = 0;
    int bad = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic ef0 = 1'b0, eo0 = 1'b0;
    logic ef1 = 1'b0, ep1 = 1'b0;

    uart_rx_oversampled u_dut0 (
        .CLK(clk), .RESET_N(rst_n), .IN_SERIAL_RX(rx0), .OUT_DATA(d0), .OUT_VALID(v0),
        .IN_READY(rdy0), .OUT_STATUS_IDLE(idle0), .OUT_ERR_FRAME(fe0), .OUT_ERR_PARITY(pe0),
        .OUT_ERR_OVERRUN(ov0), .IN_ERR_CLEAR(clr0)
    );

    uart_rx_oversampled #(
        .CLK_HZ(48_000_000), .BAUD(1_000_000), .OVERSAMPLE(8),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
    ) u_dut1 (
        .CLK(clk), .RESET_N(rst_n), .IN_SERIAL_RX(rx1), .OUT_DATA(d1), .OUT_VALID(v1),
        .IN_READY(rdy1), .OUT_STATUS_IDLE(idle1), .OUT_ERR_FRAME(fe1), .OUT_ERR_PARITY(pe1),
        .OUT_ERR_OVERRUN(ov1), .IN_ERR_CLEAR(clr1)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (v0 && rdy0) q0.push_back({1'b0, d0});
        if (v1 && rdy1) q1.push_back({2'b00, d1});
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic line0(input logic v, input int n);
        rx0 = v;
        step(n);
    endtask

    task automatic line1(input logic v, input int n);
        rx1 = v;
        step(n);
    endtask

    task automatic send0(input logic [7:0] d, input logic stopb, input int gap_bits);
        line0(1'b0, BC0);
        for (int i = 0; i < 8; i++) line0(d[i], BC0);
        line0(stopb, BC0);
        line0(1'b1, BC0 * gap_bits);
    endtask

    task automatic send1(input logic [6:0] d, input logic pb, input logic s1, input logic s2);
        line1(1'b0, BC1);
        for (int i = 0; i < 7; i++) line1(d[i], BC1);
        line1(pb, BC1);
        line1(s1, BC1);
        line1(s2, BC1);
        line1(1'b1, BC1);
    endtask

    // Waits a bounded time for one delivered word, then checks it was the only one.
    task automatic expect0(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (q0.size() == 0 && n < 50) begin
            step(1);
            n++;
        end
        chk({tag, "_present"}, 16'(q0.size() != 0), 16'd1);
        if (q0.size() != 0) chk({tag, "_data"}, 16'(q0.pop_front()), 16'(exp));
        chk({tag, "_single"}, 16'(q0.size()), 16'd0);
    endtask

    task automatic expect1(input string tag, input logic [6:0] exp);
        int n;
        n = 0;
        while (q1.size() == 0 && n < 50) begin
            step(1);
            n++;
        end
        chk({tag, "_present"}, 16'(q1.size() != 0), 16'd1);
        if (q1.size() != 0) chk({tag, "_data"}, 16'(q1.pop_front()), 16'(exp));
        chk({tag, "_single"}, 16'(q1.size()), 16'd0);
    endtask

    task automatic flags0(input string tag);
        chk({tag, "_ferr"}, 16'(fe0), 16'(ef0));
        chk({tag, "_perr"}, 16'(pe0), 16'd0);
        chk({tag, "_ovr"}, 16'(ov0), 16'(eo0));
    endtask

    task automatic flags1(input string tag);
        chk({tag, "_ferr"}, 16'(fe1), 16'(ef1));
        chk({tag, "_perr"}, 16'(pe1), 16'(ep1));
        chk({tag, "_ovr"}, 16'(ov1), 16'd0);
    endtask

    task automatic clear0();
        clr0 = 1'b1;
        step(1);
        clr0 = 1'b0;
        ef0 = 1'b0;
        eo0 = 1'b0;
    endtask

    task automatic clear1();
        clr1 = 1'b1;
        step(1);
        clr1 = 1'b0;
        ef1 = 1'b0;
        ep1 = 1'b0;
    endtask

    // Frame-level model for the 7E2 build: even parity bit equals XOR of data; any low stop is a frame error.
    task automatic frame1(input string tag, input logic [6:0] d, input logic pb, input logic s1, input logic s2);
        send1(d, pb, s1, s2);
        if (pb != (^d)) ep1 = 1'b1;
        if (!(s1 && s2)) ef1 = 1'b1;
        expect1(tag, d);
        flags1(tag);
        clear1();
        flags1({tag, "_clr"});
    endtask

    initial begin
        logic [7:0] r8;
        logic [6:0] r7;
        logic       rp, rs1, rs2;

        step(5);
        chk("rst_data0", 16'(d0), 16'd0);
        chk("rst_valid0", 16'(v0), 16'd0);
        chk("rst_idle0", 16'(idle0), 16'd1);
        flags0("rst0");
        chk("rst_valid1", 16'(v1), 16'd0);
        chk("rst_idle1", 16'(idle1), 16'd1);
        flags1("rst1");
        rst_n = 1'b1;
        step(5);

        send0(8'hA5, 1'b1, 1);
        expect0("a5", 8'hA5);
        flags0("a5");

        line0(1'b0, 150);
        line0(1'b1, 600);
        chk("glitch_noword", 16'(q0.size()), 16'd0);
        chk("glitch_idle", 16'(idle0), 16'd1);
        chk("glitch_valid", 16'(v0), 16'd0);
        send0(8'h3C, 1'b1, 1);
        expect0("after_glitch", 8'h3C);
        flags0("after_glitch");

        send0(8'h55, 1'b0, 1);
        ef0 = 1'b1;
        expect0("stop_low", 8'h55);
        flags0("stop_low");
        clear0();
        flags0("stop_low_clr");

        frame1("par_bad", 7'h3C, 1'b1, 1'b1, 1'b1);
        frame1("par_ok", 7'h3C, 1'b0, 1'b1, 1'b1);
        frame1("stop2_low", 7'h2B, 1'b0, 1'b1, 1'b0);
        frame1("stop1_low", 7'h41, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            r7  = 7'($urandom);
            rp  = ($urandom_range(0, 3) == 0) ? ~(^r7) : (^r7);
            rs1 = ($urandom_range(0, 4) != 0);
            rs2 = ($urandom_range(0, 4) != 0);
            frame1("rand1", r7, rp, rs1, rs2);
        end

        rdy0 = 1'b0;
        send0(8'h11, 1'b1, 0);
        send0(8'h22, 1'b1, 1);
        eo0 = 1'b1;
        chk("ovr_valid", 16'(v0), 16'd1);
        chk("ovr_data_kept", 16'(d0), 16'h11);
        flags0("ovr");
        rdy0 = 1'b1;
        step(1);
        expect0("ovr_pop", 8'h11);
        chk("ovr_valid_after", 16'(v0), 16'd0);
        clear0();
        flags0("ovr_clr");

        line0(1'b0, BC0);
        line0(1'b1, BC0 * 3);
        rst_n = 1'b0;
        ef0 = 1'b0;
        eo0 = 1'b0;
        step(3);
        chk("midrst_valid", 16'(v0), 16'd0);
        chk("midrst_idle", 16'(idle0), 16'd1);
        rst_n = 1'b1;
        line0(1'b1, BC0 * 6);
        chk("midrst_noword", 16'(q0.size()), 16'd0);
        send0(8'h81, 1'b1, 1);
        expect0("after_rst", 8'h81);
        flags0("after_rst");

        for (int k = 0; k < 2; k++) begin
            r8 = 8'($urandom);
            send0(r8, 1'b1, 1);
            expect0("rand0", r8);
            flags0("rand0");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
